// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// pipeline (MEM/WB) and a long-latency unit (LU). The pipeline always wins; a
// colliding LU result is parked in a 1-entry buffer. If it waits STARVE_MAX
// cycles, the pipeline is stalled for one cycle so the buffer can drain.
//
// Handshake: the LU result transfers on any cycle where lu_valid && lu_ready.
// The LU holds lu_addr/lu_data stable until that cycle. lu_ready does not
// depend on lu_valid.
//
// Optional feature: define WB_ARB_STAT_EN to count HOLD->FORCE entries on
// stat_force. The counter saturates at all-ones and is cleared only by rst.
// Without the macro, stat_force is tied to zero.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_addr,
    input  logic [31:0]      pipe_data,
    input  logic             lu_valid,
    input  logic [4:0]       lu_addr,
    input  logic [31:0]      lu_data,
    output logic             lu_ready,
    output logic             stall_req,
    output logic             rf_we,
    output logic [4:0]       rf_addr,
    output logic [31:0]      rf_data,
    output logic             pend_valid,
    output logic [4:0]       pend_addr,
    output logic [CNT_W-1:0] stat_force
);

    // The wait counter must be able to reach STARVE_MAX.
    localparam int WC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [4:0]        buf_addr_q, buf_addr_d;
    logic [31:0]       buf_data_q, buf_data_d;

    logic              pipe_wr;
    logic              lu_live;
    logic              force_entry;
    logic              rf_we_c;
    logic              lu_ready_c;
    logic              stall_c;

    // Writes to x0 are never real writes. An LU result for x0 is accepted and dropped.
    assign pipe_wr = pipe_we && (pipe_addr != 5'd0);
    assign lu_live = lu_valid && (lu_addr != 5'd0);

    // Next-state and write-port selection; the rf write happens in the same cycle.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        rf_we_c     = 1'b0;
        rf_addr     = 5'd0;
        rf_data     = 32'd0;
        lu_ready_c  = 1'b0;
        stall_c     = 1'b0;
        force_entry = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lu_ready_c = 1'b1;
                if (pipe_wr) begin
                    rf_we_c = 1'b1;
                    rf_addr = pipe_addr;
                    rf_data = pipe_data;
                    if (lu_live) begin
                        buf_addr_d = lu_addr;
                        buf_data_d = lu_data;
                        wait_cnt_d = '0;
                        state_d    = ST_HOLD;
                    end
                end else if (lu_live) begin
                    rf_we_c = 1'b1;
                    rf_addr = lu_addr;
                    rf_data = lu_data;
                end
            end
            ST_HOLD: begin
                if (!pipe_wr) begin
                    rf_we_c = 1'b1;
                    rf_addr = buf_addr_q;
                    rf_data = buf_data_q;
                    state_d = ST_IDLE;
                end else begin
                    rf_we_c    = 1'b1;
                    rf_addr    = pipe_addr;
                    rf_data    = pipe_data;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d     = ST_FORCE;
                        force_entry = 1'b1;
                    end
                end
            end
            ST_FORCE: begin
                // MEM/WB is held by the stall, so the suppressed pipe write repeats next cycle.
                stall_c = 1'b1;
                rf_we_c = 1'b1;
                rf_addr = buf_addr_q;
                rf_data = buf_data_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, wait counter and parking buffer; reset discards any parked result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            buf_addr_q <= 5'd0;
            buf_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    // Outputs are forced quiet while rst is high.
    assign rf_we      = rf_we_c && !rst;
    assign lu_ready   = lu_ready_c && !rst;
    assign stall_req  = stall_c && !rst;
    assign pend_valid = (state_q != ST_IDLE) && !rst;
    assign pend_addr  = rst ? 5'd0 : buf_addr_q;

`ifdef WB_ARB_STAT_EN
    logic [CNT_W-1:0] stat_q;

    // Saturating count of HOLD->FORCE transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (force_entry && (stat_q != {CNT_W{1'b1}})) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_force = stat_q;
`else
    logic unused_force_entry;
    assign unused_force_entry = force_entry;
    assign stat_force = '0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter (STARVE_MAX = 4).
// Inputs change just after the falling edge; the combinational outputs are
// sampled 2 time units later, well before the next rising edge.
module tb_wb_port_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 16;
`ifdef WB_ARB_STAT_EN
    localparam logic [31:0] EXP_STAT_AFTER_FORCE = 32'd1;
`else
    localparam logic [31:0] EXP_STAT_AFTER_FORCE = 32'd0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             pipe_we;
    logic [4:0]       pipe_addr;
    logic [31:0]      pipe_data;
    logic             lu_valid;
    logic [4:0]       lu_addr;
    logic [31:0]      lu_data;
    logic             lu_ready;
    logic             stall_req;
    logic             rf_we;
    logic [4:0]       rf_addr;
    logic [31:0]      rf_data;
    logic             pend_valid;
    logic [4:0]       pend_addr;
    logic [CNT_W-1:0] stat_force;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_addr  (pipe_addr),
        .pipe_data  (pipe_data),
        .lu_valid   (lu_valid),
        .lu_addr    (lu_addr),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .stall_req  (stall_req),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .stat_force (stat_force)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_we   = pwe;
        pipe_addr = pa;
        pipe_data = pd;
        lu_valid  = lv;
        lu_addr   = la;
        lu_data   = ld;
        #2;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the write port and the handshake/status outputs in one call.
    task automatic chk_port(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic rdy, input logic stl,
                            input logic pv);
        chk({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, we});
        if (we) begin
            chk({tag, ".rf_addr"}, {27'd0, rf_addr}, {27'd0, a});
            chk({tag, ".rf_data"}, rf_data, d);
        end
        chk({tag, ".lu_ready"},   {31'd0, lu_ready},   {31'd0, rdy});
        chk({tag, ".stall_req"},  {31'd0, stall_req},  {31'd0, stl});
        chk({tag, ".pend_valid"}, {31'd0, pend_valid}, {31'd0, pv});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        next_cycle();

        // Reset: outputs forced quiet even with a live pipe write.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'hAA);
        chk_port("rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst.pend_addr", {27'd0, pend_addr}, 32'd0);
        chk("rst.stat_force", 32'(stat_force), 32'd0);
        next_cycle();
        rst = 1'b0;

        // 1: plain pipe write.
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        chk_port("t1", 1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // 2: direct LU write, stays IDLE.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
        chk_port("t2", 1'b1, 5'd7, 32'hAA, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_port("t2.after", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // 3: collision then drain on the first free cycle.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'hAA);
        chk_port("t3.c0", 1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_port("t3.c1", 1'b1, 5'd7, 32'hAA, 1'b0, 1'b0, 1'b1);
        chk("t3.c1.pend_addr", {27'd0, pend_addr}, 32'd7);
        next_cycle();
        chk_port("t3.c2", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // 4: starvation -> 4 HOLD cycles, 1 FORCE cycle, then the held pipe write.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd7, 32'hBB);
        chk_port("t4.c0", 1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int i = 0; i < STARVE_MAX; i++) begin
            drive(1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
            chk_port($sformatf("t4.hold%0d", i), 1'b1, 5'(8 + i), 32'h100 + 32'(i),
                     1'b0, 1'b0, 1'b1);
            chk($sformatf("t4.hold%0d.pend_addr", i), {27'd0, pend_addr}, 32'd7);
            next_cycle();
        end
        drive(1'b1, 5'd12, 32'h200, 1'b0, 5'd0, 32'd0);
        chk_port("t4.force", 1'b1, 5'd7, 32'hBB, 1'b0, 1'b1, 1'b1);
        next_cycle();
        drive(1'b1, 5'd12, 32'h200, 1'b0, 5'd0, 32'd0);
        chk_port("t4.retry", 1'b1, 5'd12, 32'h200, 1'b1, 1'b0, 1'b0);
        chk("t4.stat_force", 32'(stat_force), EXP_STAT_AFTER_FORCE);
        next_cycle();

        // 5: LU result for x0 alongside a pipe write is accepted and dropped.
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd0, 32'hDEAD);
        chk_port("t5.c0", 1'b1, 5'd5, 32'h55, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_port("t5.c1", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        next_cycle();

        // 6: reset while HOLD discards the parked result.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'hCC);
        chk_port("t6.c0", 1'b1, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0);
        next_cycle();
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        chk_port("t6.hold", 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 1'b1);
        chk("t6.hold.pend_addr", {27'd0, pend_addr}, 32'd9);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_port("t6.rst", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("t6.rst.pend_addr", {27'd0, pend_addr}, 32'd0);
        next_cycle();
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk_port("t6.after", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        chk("t6.after.stat_force", 32'(stat_force), 32'd0);
        next_cycle();
        chk_port("t6.after2", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
